out_port_unit: RTL and testbench
================================

Name: out_port_unit

Overview:
- Output-port side of the CPU datapath: the counterpart of the In.Port path, used by the "out" instruction.
- On the control step that asserts Out_Portin, the unit captures the word on the datapath bus into a small FIFO.
- It presents the oldest queued word to an external device over a valid/ready handshake.
- Back-pressure is reported to the control unit via Out_Port_full, so an "out" is not issued into a full queue.

Parameters:
- WIDTH, 32, data word width; equals the datapath bus width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, count width; must equal log2(DEPTH)+1.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Clear  input  1  synchronous, active-high reset; sampled on the rising edge of Clock.
- Out_Portin  input  1  push request; captures BusMuxOut at this edge.
- BusMuxOut  input  WIDTH  datapath bus.
- Out_Port_data  output  WIDTH  head-of-queue word to the external device.
- Out_Port_valid  output  1  Out_Port_data holds a valid word.
- Out_Port_ready  input  1  device accepts the word this cycle.
- Out_Port_full  output  1  count == DEPTH.
- Out_Port_count  output  CW  number of queued words.
- Out_Port_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset: Clear=1 at an edge empties the FIFO and has priority over push and pop in the same cycle.
  - Reset values: read/write pointers 0, Out_Port_count 0, Out_Port_valid 0, Out_Port_full 0, Out_Port_ovf 0, Out_Port_data 0.
  - Clear mid-transfer discards all queued words.
- Storage: circular buffer of DEPTH x WIDTH registers; write pointer and read pointer each wrap DEPTH-1 -> 0.
- First-word fall-through:
  - Out_Port_data = mem[rd_ptr] whenever count != 0; otherwise it shows 0.
  - Out_Port_valid = (count != 0), derived combinationally from the registered count.
- push = Out_Portin. pop = Out_Port_valid & Out_Port_ready.
- Push accepted when count < DEPTH, or when count == DEPTH and pop occurs in the same cycle.
- Push when full and no pop: word is dropped, no state changes except Out_Port_ovf <= 1. The flag stays set until Clear.
- Latency: a word pushed at edge N is visible with Out_Port_valid=1 in the cycle after edge N (1-cycle latency).
- Pop at edge N advances rd_ptr, so the next word (if any) appears after edge N.
- Count update:
  - push only: +1
  - pop only: -1
  - accepted push + pop together: unchanged, and both pointers advance.
- Pop with count == 0 cannot occur, because valid=0. Out_Port_ready is ignored when valid=0.
- Ordering is strict FIFO; words are never duplicated or reordered.
- Out_Port_data holds stable while valid=1 and ready=0.
- Out_Port_full is derived combinationally from the registered count.

Optional Feature:
- Macro: OUT_PORT_LAST_EN.
- Defined: adds output port Out_Port_last [WIDTH-1:0].
  - Register loads the popped word at each pop edge; reset value 0 on Clear.
  - Intended to drive the board display with the last word delivered.
- Not defined: the port and the register are absent; all other behaviour is identical.

Test Plan:
- Clear at edge 1, then idle -> valid=0, count=0, full=0, ovf=0, Out_Port_data=0.
- Out_Portin=1 with BusMuxOut=32'h0000_00A5 for one cycle, ready=0 -> next cycle valid=1, data=32'hA5, count=1. Raise ready for one cycle -> valid=0, count=0 (with OUT_PORT_LAST_EN: Out_Port_last=32'hA5).
- Push 1,2,3,4 on consecutive edges with ready=0 -> count=4, full=1. A 5th push of 5 -> dropped, ovf=1, count=4. Then ready=1 for 4 cycles -> data sequence 1,2,3,4, then valid=0; ovf stays 1.
- Fill to 4 (10,11,12,13), then push 14 with ready=1 in the same cycle -> 10 popped, 14 accepted, count=4, ovf=0. Drain order 11,12,13,14.
- Wrap-around: push/pop 6 words one at a time (values 6'h20..6'h25) -> each delivered in order; pointers wrap past index 3 without loss.
- Count=3 with data queued, assert Clear together with Out_Portin=1 and ready=1 -> next cycle count=0, valid=0, ovf=0, data=0; the pushed word is not stored.

Source files
------------

// File: rtl/out_port_unit_if.sv
// Bundles the bus-capture and device-handshake signals of the output port.
// With OUT_PORT_LAST_EN defined, it also carries Out_Port_last.
interface out_port_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 3
);
    logic             Out_Portin;
    logic [WIDTH-1:0] BusMuxOut;
    logic [WIDTH-1:0] Out_Port_data;
    logic             Out_Port_valid;
    logic             Out_Port_ready;
    logic             Out_Port_full;
    logic [CW-1:0]    Out_Port_count;
    logic             Out_Port_ovf;
`ifdef OUT_PORT_LAST_EN
    logic [WIDTH-1:0] Out_Port_last;

    modport slave (
        input  Out_Portin, BusMuxOut, Out_Port_ready,
        output Out_Port_data, Out_Port_valid, Out_Port_full,
               Out_Port_count, Out_Port_ovf, Out_Port_last
    );
    modport master (
        output Out_Portin, BusMuxOut, Out_Port_ready,
        input  Out_Port_data, Out_Port_valid, Out_Port_full,
               Out_Port_count, Out_Port_ovf, Out_Port_last
    );
`else
    modport slave (
        input  Out_Portin, BusMuxOut, Out_Port_ready,
        output Out_Port_data, Out_Port_valid, Out_Port_full,
               Out_Port_count, Out_Port_ovf
    );
    modport master (
        output Out_Portin, BusMuxOut, Out_Port_ready,
        input  Out_Port_data, Out_Port_valid, Out_Port_full,
               Out_Port_count, Out_Port_ovf
    );
`endif
endinterface

// File: rtl/out_port_unit.sv
// Output-port FIFO: captures the datapath bus on Out_Portin and hands words to a device
// over valid/ready. Optional macro OUT_PORT_LAST_EN adds the Out_Port_last register.
module out_port_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          Clock,
    input  logic          Clear,
    out_port_unit_if.slave port
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             valid_c, full_c, pop_c, push_ok_c;
    logic [WIDTH-1:0] head_c;

    // Full-with-pop still accepts the push because a slot frees on the same edge.
    always_comb begin
        valid_c   = (count_q != '0);
        full_c    = (count_q == CW'(DEPTH));
        pop_c     = valid_c & port.Out_Port_ready;
        push_ok_c = port.Out_Portin & (~full_c | pop_c);
        head_c    = mem_q[rd_ptr_q];

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)     rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (port.Out_Portin & full_c & ~pop_c) ovf_d = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: empty entries are masked off the output.
    always_ff @(posedge Clock) begin
        if (!Clear && push_ok_c) mem_q[wr_ptr_q] <= port.BusMuxOut;
    end

`ifdef OUT_PORT_LAST_EN
    logic [WIDTH-1:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (pop_c) last_d = head_c;
    end

    always_ff @(posedge Clock) begin
        if (Clear) last_q <= '0;
        else       last_q <= last_d;
    end

    assign port.Out_Port_last = last_q;
`endif

    assign port.Out_Port_data  = valid_c ? head_c : '0;
    assign port.Out_Port_valid = valid_c;
    assign port.Out_Port_full  = full_c;
    assign port.Out_Port_count = count_q;
    assign port.Out_Port_ovf   = ovf_q;

endmodule

// File: tb/tb_out_port_unit.sv
// Self-checking bench for out_port_unit: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_out_port_unit;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic Clock;
    logic Clear;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    out_port_unit_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    out_port_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .port  (bus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of delivered-in-order words.
    logic [31:0] mq[$];
    logic        m_ovf  = 1'b0;
    logic [31:0] m_last = '0;

    always @(posedge Clock) begin
        if (Clear) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_last = '0;
        end else begin
            if (mq.size() != 0 && bus.Out_Port_ready) begin
                m_last = mq[0];
                void'(mq.pop_front());
            end
            if (bus.Out_Portin) begin
                if (mq.size() < DEPTH) mq.push_back(bus.BusMuxOut);
                else                   m_ovf = 1'b1;
            end
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("m_valid", 32'(bus.Out_Port_valid), 32'(mq.size() != 0));
            chk("m_data",  bus.Out_Port_data, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("m_count", 32'(bus.Out_Port_count), 32'(mq.size()));
            chk("m_full",  32'(bus.Out_Port_full), 32'(mq.size() == DEPTH));
            chk("m_ovf",   32'(bus.Out_Port_ovf), 32'(m_ovf));
`ifdef OUT_PORT_LAST_EN
            chk("m_last",  bus.Out_Port_last, m_last);
`endif
        end
    end

    // One clock: apply inputs, take the edge, return 1ns after it.
    task automatic cyc(input logic c, input logic p, input logic [31:0] d, input logic r);
        Clear              = c;
        bus.Out_Portin     = p;
        bus.BusMuxOut      = d;
        bus.Out_Port_ready = r;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Clear              = 1'b0;
        bus.Out_Portin     = 1'b0;
        bus.BusMuxOut      = '0;
        bus.Out_Port_ready = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0);
        chk_en = 1;
        cyc(0, 0, 0, 0);
        chk("rst_valid", 32'(bus.Out_Port_valid), 0);
        chk("rst_count", 32'(bus.Out_Port_count), 0);
        chk("rst_full",  32'(bus.Out_Port_full), 0);
        chk("rst_ovf",   32'(bus.Out_Port_ovf), 0);
        chk("rst_data",  bus.Out_Port_data, 0);

        // Single word
        cyc(0, 1, 32'h0000_00A5, 0);
        chk("one_valid", 32'(bus.Out_Port_valid), 1);
        chk("one_data",  bus.Out_Port_data, 32'hA5);
        chk("one_count", 32'(bus.Out_Port_count), 1);
        cyc(0, 0, 0, 1);
        chk("one_pop_valid", 32'(bus.Out_Port_valid), 0);
        chk("one_pop_count", 32'(bus.Out_Port_count), 0);
`ifdef OUT_PORT_LAST_EN
        chk("one_last", bus.Out_Port_last, 32'hA5);
`endif

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) cyc(0, 1, 32'(i), 0);
        chk("fill_count", 32'(bus.Out_Port_count), 4);
        chk("fill_full",  32'(bus.Out_Port_full), 1);
        cyc(0, 1, 32'd5, 0);
        chk("ovf_flag",  32'(bus.Out_Port_ovf), 1);
        chk("ovf_count", 32'(bus.Out_Port_count), 4);
        chk("ovf_head",  bus.Out_Port_data, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", bus.Out_Port_data, 32'(i));
            cyc(0, 0, 0, 1);
        end
        chk("drain_valid", 32'(bus.Out_Port_valid), 0);
        chk("ovf_sticky",  32'(bus.Out_Port_ovf), 1);

        // Push into full queue while popping
        cyc(1, 0, 0, 0);
        for (int i = 10; i <= 13; i++) cyc(0, 1, 32'(i), 0);
        chk("fp_count_pre", 32'(bus.Out_Port_count), 4);
        cyc(0, 1, 32'd14, 1);
        chk("fp_count", 32'(bus.Out_Port_count), 4);
        chk("fp_ovf",   32'(bus.Out_Port_ovf), 0);
`ifdef OUT_PORT_LAST_EN
        chk("fp_last",  bus.Out_Port_last, 32'd10);
`endif
        for (int i = 11; i <= 14; i++) begin
            chk("fp_drain", bus.Out_Port_data, 32'(i));
            cyc(0, 0, 0, 1);
        end
        chk("fp_empty", 32'(bus.Out_Port_valid), 0);

        // Wrap-around, one word at a time
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 32'h20 + 32'(i), 0);
            chk("wrap_data",  bus.Out_Port_data, 32'h20 + 32'(i));
            chk("wrap_count", 32'(bus.Out_Port_count), 1);
            cyc(0, 0, 0, 1);
            chk("wrap_empty", 32'(bus.Out_Port_valid), 0);
        end

        // Clear beats simultaneous push and pop
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h30 + 32'(i), 0);
        chk("clr_pre_count", 32'(bus.Out_Port_count), 3);
        chk("clr_pre_data",  bus.Out_Port_data, 32'h30);
        cyc(1, 1, 32'h99, 1);
        chk("clr_count", 32'(bus.Out_Port_count), 0);
        chk("clr_valid", 32'(bus.Out_Port_valid), 0);
        chk("clr_ovf",   32'(bus.Out_Port_ovf), 0);
        chk("clr_data",  bus.Out_Port_data, 0);
        cyc(0, 0, 0, 0);
        chk("clr_idle_count", 32'(bus.Out_Port_count), 0);
`ifdef OUT_PORT_LAST_EN
        chk("clr_last", bus.Out_Port_last, 0);
`endif

        cyc(0, 0, 0, 0);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
